spin_motor_ramp_ctrl: RTL

Consumer of the selected spin speed. Latches an 11-bit target rpm on start and ramps the motor speed up at a fixed step per ramp tick. It then holds for a programmed number of ticks and ramps back down to 0. Drives a PWM output proportional to current speed and sits between the spin-speed selector and the motor driver.

---
 rtl/spin_pkg.sv | 27 ++
 rtl/spin_tick_gen.sv | 30 +++
 rtl/spin_motor_ramp_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/spin_pkg.sv
// Shared types and speed constants for the spin motor ramp controller.
// SPIN_IMBALANCE_EN adds the DERATE state.
package spin_pkg;

    localparam int SPEED_W = 11;

    typedef logic [SPEED_W-1:0] spin_speed_t;

    localparam spin_speed_t SPEED_400  = 11'd400;
    localparam spin_speed_t SPEED_800  = 11'd800;
    localparam spin_speed_t SPEED_1200 = 11'd1200;
    localparam spin_speed_t SPEED_1400 = 11'd1400;
    localparam spin_speed_t MAX_SPEED  = SPEED_1400;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RAMP_UP,
        ST_HOLD,
        ST_RAMP_DOWN,
        ST_DONE
`ifdef SPIN_IMBALANCE_EN
        ,
        ST_DERATE
`endif
    } spin_state_t;

endpackage

// File: rtl/spin_tick_gen.sv
// Ramp tick divider: counts 0..TICK_DIV-1 while enabled and emits a one-cycle
// tick on the last count.
module spin_tick_gen #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

    assign tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/spin_motor_ramp_ctrl.sv
// Spin motor speed ramp: latch target, ramp up, hold, ramp down, plus PWM drive.
// Optional imbalance derating is enabled with SPIN_IMBALANCE_EN.
//
// state        | meaning
// -------------+------------------------------------------------
// ST_IDLE      | waiting for start, speed 0
// ST_RAMP_UP   | +min(step, tgt-cur) per tick until cur == tgt
// ST_HOLD      | at target, counting hold_len ticks
// ST_RAMP_DOWN | -min(step, cur) per tick until 0
// ST_DONE      | one-cycle completion pulse
// ST_DERATE    | (imbalance build) stepping down to derated target
module spin_motor_ramp_ctrl
    import spin_pkg::*;
#(
    parameter int TICK_DIV  = 4,
    parameter int RAMP_STEP = 100,
    parameter int MAX_SPEED = int'(spin_pkg::MAX_SPEED)
`ifdef SPIN_IMBALANCE_EN
    ,
    parameter int IMB_SPEED = 400
`endif
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [10:0] target_speed,
    input  logic        start,
    input  logic        stop,
    input  logic [15:0] spin_ticks,
`ifdef SPIN_IMBALANCE_EN
    input  logic        imbalance,
`endif
    output logic [10:0] current_speed,
    output logic        motor_pwm,
    output logic        busy,
    output logic        at_speed,
    output logic        done
);

    localparam spin_speed_t STEP = spin_speed_t'(RAMP_STEP);
    localparam spin_speed_t TOP  = spin_speed_t'(MAX_SPEED);

    spin_state_t state, state_n;
    spin_speed_t cur, cur_n, tgt, tgt_n, tgt_eff, lat;
    spin_speed_t up_diff, up_step, dn_step;
    logic [15:0] hold_len, hold_len_n, hold_cnt, hold_cnt_n;
    spin_speed_t pwm_cnt;
    logic        tick;
`ifdef SPIN_IMBALANCE_EN
    localparam spin_speed_t IMB = spin_speed_t'(IMB_SPEED);
    spin_speed_t drt_diff, drt_step;
`endif

    spin_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (state != ST_IDLE),
        .clr     (state == ST_IDLE),
        .tick    (tick)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            cur      <= '0;
            tgt      <= '0;
            hold_len <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_n;
            cur      <= cur_n;
            tgt      <= tgt_n;
            hold_len <= hold_len_n;
            hold_cnt <= hold_cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        cur_n      = cur;
        hold_len_n = hold_len;
        hold_cnt_n = hold_cnt;
        tgt_eff    = tgt;
`ifdef SPIN_IMBALANCE_EN
        // Derated target takes effect in the same cycle imbalance is seen.
        if (imbalance && (state == ST_RAMP_UP || state == ST_HOLD) && tgt > IMB)
            tgt_eff = IMB;
        drt_diff = (cur > tgt_eff) ? cur - tgt_eff : '0;
        drt_step = (drt_diff < STEP) ? drt_diff : STEP;
`endif
        tgt_n   = tgt_eff;
        lat     = (target_speed > TOP) ? TOP : target_speed;
        up_diff = (tgt_eff > cur) ? tgt_eff - cur : '0;
        up_step = (up_diff < STEP) ? up_diff : STEP;
        dn_step = (cur < STEP) ? cur : STEP;

        case (state)
            ST_IDLE: begin
                if (start && !stop) begin
                    tgt_n      = lat;
                    hold_len_n = spin_ticks;
                    hold_cnt_n = '0;
                    state_n    = (lat == '0) ? ST_DONE : ST_RAMP_UP;
                end
            end
            ST_RAMP_UP: begin
                if (stop) begin
                    state_n = ST_RAMP_DOWN;
`ifdef SPIN_IMBALANCE_EN
                end else if (cur > tgt_eff) begin
                    state_n = ST_DERATE;
`endif
                end else if (tick) begin
                    cur_n = cur + up_step;
                    if (cur + up_step == tgt_eff) state_n = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (stop) begin
                    state_n = ST_RAMP_DOWN;
`ifdef SPIN_IMBALANCE_EN
                end else if (cur > tgt_eff) begin
                    state_n = ST_DERATE;
`endif
                end else if (hold_len == '0) begin
                    state_n = ST_RAMP_DOWN;
                end else if (tick) begin
                    hold_cnt_n = hold_cnt + 16'd1;
                    if (hold_cnt + 16'd1 == hold_len) state_n = ST_RAMP_DOWN;
                end
            end
`ifdef SPIN_IMBALANCE_EN
            ST_DERATE: begin
                if (stop) begin
                    state_n = ST_RAMP_DOWN;
                end else if (tick) begin
                    cur_n = cur - drt_step;
                    if (cur - drt_step == tgt) state_n = ST_HOLD;
                end
            end
`endif
            ST_RAMP_DOWN: begin
                if (tick) begin
                    cur_n = cur - dn_step;
                    if (cur == dn_step) state_n = ST_DONE;
                end
            end
            ST_DONE:  state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    // PWM period is MAX_SPEED cycles; output is registered, one cycle behind cur.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pwm_cnt   <= '0;
            motor_pwm <= 1'b0;
        end else begin
            pwm_cnt   <= (pwm_cnt == TOP - 11'd1) ? '0 : pwm_cnt + 11'd1;
            motor_pwm <= (pwm_cnt < cur);
        end
    end

    assign current_speed = cur;
    assign busy          = (state != ST_IDLE);
    assign at_speed      = (state == ST_HOLD);
    assign done          = (state == ST_DONE);

endmodule
